// File: rtl/buffer_pool_reader_if.sv
// Bundle of the command handshake, pool read port and output stream
// of buffer_pool_reader. slave = controller side, master = driver side.
interface buffer_pool_reader_if #(
    parameter int unsigned X_MAC    = 4,
    parameter int unsigned X_MESH   = 16,
    parameter int unsigned ADDR_LEN = 13,
    parameter int unsigned DATA_LEN = 32
);
    localparam int unsigned BUFFER_NUM = X_MAC * X_MESH;
    localparam int unsigned DATAWIDTH  = BUFFER_NUM * DATA_LEN;
    localparam int unsigned ADDRWIDTH  = BUFFER_NUM * ADDR_LEN;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_LEN-1:0]   cmd_base;
    logic [ADDR_LEN:0]     cmd_len;
    logic [ADDR_LEN-1:0]   cmd_stride;
    logic [ADDRWIDTH-1:0]  addrb;
    logic [DATAWIDTH-1:0]  doutb;
    logic [DATAWIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, cmd_stride, doutb, out_ready,
        output cmd_ready, addrb, out_data, out_valid, out_last, busy
    );

    modport master (
        output cmd_valid, cmd_base, cmd_len, cmd_stride, doutb, out_ready,
        input  cmd_ready, addrb, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/buffer_pool_reader.sv
// Read-side controller for the banked BRAM buffer pool.
// Takes a (base, len, stride) command, issues one broadcast read address per
// cycle under a credit limit, realigns the pool read latency and streams the
// words out through a small first-word-fall-through FIFO.
// Optional macro BUFREAD_PERF_EN adds the perf_stall_cnt output.
module buffer_pool_reader #(
    parameter int unsigned X_MAC      = 4,
    parameter int unsigned X_MESH     = 16,
    parameter int unsigned ADDR_LEN   = 13,
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BUFREAD_PERF_EN
    output logic [31:0]          perf_stall_cnt,
`endif
    buffer_pool_reader_if.slave  bus
);
    localparam int unsigned BUFFER_NUM = X_MAC * X_MESH;
    localparam int unsigned DATAWIDTH  = BUFFER_NUM * DATA_LEN;
    localparam int unsigned LEN_W      = ADDR_LEN + 1;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_d;

    logic [ADDR_LEN-1:0]  addr;
    logic [ADDR_LEN-1:0]  stride;
    logic [LEN_W-1:0]     remaining;
    logic [ADDR_LEN-1:0]  addr_q;

    logic                 iss_v;
    logic                 iss_l;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [RD_LATENCY-1:0] pipe_l;

    logic [DATAWIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;

    logic                 accept;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 head_last;
    logic                 last_issue;
    logic                 credit_ok;
    logic [OUT_W-1:0]     in_flight;
    logic [OUT_W-1:0]     outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push       = pipe_v[RD_LATENCY-1];
    assign pop        = (count != '0) && bus.out_ready;
    assign head_last  = fifo_last[rd_ptr];
    assign last_issue = (remaining == LEN_W'(1));

    // Words already committed to the FIFO: issue register, latency pipe and FIFO.
    always_comb begin
        in_flight = OUT_W'(iss_v);
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + OUT_W'(pipe_v[i]);
        end
    end

    // A word leaving the FIFO this cycle frees its slot for a new issue,
    // which keeps one word per cycle with the stream ready.
    assign outstanding = in_flight + OUT_W'(count);
    assign credit_ok   = (outstanding - OUT_W'(pop)) < OUT_W'(FIFO_DEPTH);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and issue/accept decode.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.cmd_valid;
                if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, address walk and the registered pool address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            stride    <= '0;
            remaining <= '0;
            addr_q    <= '0;
        end else if (accept) begin
            addr      <= bus.cmd_base;
            stride    <= bus.cmd_stride;
            remaining <= bus.cmd_len;
        end else if (issue) begin
            addr_q    <= addr;
            addr      <= addr + stride;
            remaining <= remaining - LEN_W'(1);
        end
    end

    // {valid,last} follow the address through the pool latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_v  <= 1'b0;
            iss_l  <= 1'b0;
            pipe_v <= '0;
            pipe_l <= '0;
        end else begin
            iss_v     <= issue;
            iss_l     <= issue && last_issue;
            pipe_v[0] <= iss_v;
            pipe_l[0] <= iss_l;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

    // Output FIFO: write on pipe exit, read on stream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.doutb;
                fifo_last[wr_ptr] <= pipe_l[RD_LATENCY-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit limit must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

    assign bus.addrb     = {BUFFER_NUM{addr_q}};
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_valid = (count != '0);
    assign bus.out_last  = (count != '0) && head_last;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

`ifdef BUFREAD_PERF_EN
    // Cycles the stream was held off by the consumer, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (accept) begin
            perf_stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/buffer_pool_reader.md
Name: buffer_pool_reader

Overview:
Read-side controller for the banked BRAM buffer pool (X_MAC*X_MESH banks, registered-output BRAMs). It accepts a read command (base, length, stride) and generates the common read address, broadcast to every bank's port-B slice. It aligns the fixed BRAM read latency and delivers full-width words as a valid/ready stream with backpressure. It sits between the buffer pool and the downstream MAC mesh.

Parameters:
X_MAC, 4, MAC lanes per mesh port
X_MESH, 16, mesh ports
ADDR_LEN, 13, per-bank address width
DATA_LEN, 32, per-bank data width
RD_LATENCY, 2, pool read latency in cycles, from addrb to doutb
FIFO_DEPTH, 4, output skid FIFO depth; must be >= RD_LATENCY+1
BUFFER_NUM, X_MAC*X_MESH, derived
DATAWIDTH, BUFFER_NUM*DATA_LEN, derived
ADDRWIDTH, BUFFER_NUM*ADDR_LEN, derived

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_base  in  ADDR_LEN  first word address
cmd_len  in  ADDR_LEN+1  word count, 0..2^ADDR_LEN
cmd_stride  in  ADDR_LEN  address increment per word
addrb  out  ADDRWIDTH  pool read address; the same ADDR_LEN value replicated into every bank slice
doutb  in  DATAWIDTH  pool read data
out_data  out  DATAWIDTH  stream data, driven from the FIFO head
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  marks the final word of a command
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: cmd_ready=1, addrb=0, out_valid=0, out_last=0, out_data=0, busy=0. All counters, the valid pipeline and the FIFO are cleared. Reset asserted mid-command aborts it; no beats appear after reset.
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE: when cmd_valid&&cmd_ready, latch base, len and stride. Go to ISSUE if len!=0. If len==0, the command is a no-op: stay in IDLE, emit nothing, keep cmd_ready=1.
- ISSUE:
  - A read issues in a cycle when outstanding < FIFO_DEPTH, where outstanding = words in the latency pipe + words in the FIFO.
  - On issue: addrb (registered) takes the current address; the address advances by stride modulo 2^ADDR_LEN (wraps silently); the remaining count decrements.
  - The last issue (remaining==1) tags the word last and moves the FSM to DRAIN.
  - When no read issues, addrb holds its previous value.
- Latency pipe: a RD_LATENCY-deep shift register of {valid,last}, aligned so doutb is sampled exactly RD_LATENCY cycles after addrb changes. A valid stage writes {doutb,last} into the FIFO.
- The credit rule guarantees the FIFO never overflows; overflow is a design error and is covered by an assertion.
- DRAIN: return to IDLE in the cycle after the beat carrying out_last is accepted (out_valid&&out_ready&&out_last). cmd_ready rises in that IDLE cycle.
- Stream rules:
  - out_valid = FIFO non-empty.
  - out_data and out_last must stay stable while out_valid&&!out_ready.
  - A simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- Throughput: with out_ready held high, one word per cycle. The first word appears RD_LATENCY+2 cycles after command acceptance: 1 cycle to latch, 1 cycle for the addrb register, RD_LATENCY cycles in the pool. The FIFO is first-word-fall-through.
- Wrap case: base=2^ADDR_LEN-1, stride=1 reads the top word, then address 0.
- Maximum length: cmd_len=2^ADDR_LEN reads the whole bank; the count must not truncate.

Optional Feature:
BUFREAD_PERF_EN:
- Defined: adds output port perf_stall_cnt[31:0].
  - Increments each cycle out_valid&&!out_ready; saturates at 0xFFFFFFFF.
  - Cleared on reset and on command acceptance.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Basic read: preload bank k address a with {k,a}; cmd base=0x10, len=8, stride=1, out_ready=1 -> 8 consecutive beats, addresses 0x10..0x17, first beat 4 cycles after acceptance, out_last on beat 8, cmd_ready high the following cycle.
- Stride and wrap: base=0x1FFE, len=4, stride=3 -> addresses 0x1FFE, 0x0001, 0x0004, 0x0007, in order.
- Backpressure: len=16, out_ready toggles 1 cycle on / 3 off -> all 16 words, in order, none lost or duplicated. outstanding never exceeds 4. Data stays stable while stalled.
- Zero length: cmd len=0 -> no beats, busy stays 0, a next command is accepted the following cycle.
- Reset mid-command: assert rst after 5 of 20 words -> out_valid=0 and cmd_ready=1 immediately. A new len=2 command then yields exactly 2 correct beats.
- Perf counter (BUFREAD_PERF_EN): len=4, out_ready=0 for 10 cycles after the first valid, then 1 -> perf_stall_cnt=10.
